ibex_ipm_issue: RTL
===================

// Module: ibex_ipm_issue
// PURPOSE
//  ID-side initiator for the EX-stage IPM unit. Captures a decoded IPM instruction and drives
//  ipm_operator/operands/en/sel into EX. Stalls ID until ipm_valid, then returns the result to the
//  register file through a valid/ready write port. Adds an abort path (flush), a hang timeout and a
//  retired-op counter.
// PARAMETERS
//  TimeoutCycles  64  max cycles in BUSY without ipm_valid_i before abort; legal range 1..1023
// PORTS
//  clk_i            in   1    clock
//  rst_ni           in   1    async reset, active low
//  instr_valid_i    in   1    decoded instruction valid in ID
//  ipm_instr_i      in   1    instruction is an IPM op
//  ipm_operator_i   in   ipm_op_e  decoded IPM operator
//  rs1_data_i       in   32   operand a
//  rs2_data_i       in   32   operand b
//  rd_addr_i        in   5    destination register
//  flush_i          in   1    controller flush/kill
//  stall_id_o       out  1    hold ID stage
//  instr_done_o     out  1    1-cycle pulse: IPM instruction retired
//  ipm_timeout_o    out  1    1-cycle pulse: op aborted by timeout
//  ipm_operator_o   out  ipm_op_e  to EX ipm_operator_i
//  ipm_operand_a_o  out  32   to EX ipm_operand_a_i
//  ipm_operand_b_o  out  32   to EX ipm_operand_b_i
//  ipm_en_o         out  1    dynamic enable (FSM control in IPM unit)
//  ipm_sel_o        out  1    static select (EX result/valid mux)
//  ipm_ready_id_o   out  1    ID accepts the IPM result this cycle
//  ipm_result_i     in   32   IPM result from EX
//  ipm_valid_i      in   1    IPM result valid
//  rf_we_o          out  1    register-file write request (valid)
//  rf_waddr_o       out  5    write address
//  rf_wdata_o       out  32   write data
//  rf_ready_i       in   1    write port granted
//  ipm_retired_o    out  32   count of retired IPM ops; wraps at 2^32
// BEHAVIOUR
//  Reset: state=IDLE; all outputs, operand/result/rd/operator regs and counters reset to 0.
//  FSM: IDLE, BUSY, WB.
//  - IDLE: instr_valid_i & ipm_instr_i & !flush_i -> capture operator, rs1, rs2, rd; timer=0 -> BUSY.
//    stall_id_o is asserted combinationally in the capture cycle. Otherwise stay; outputs idle.
//  - BUSY: ipm_en_o=1, ipm_sel_o=1, operands/operator driven from the capture regs, stable the
//    whole time. stall_id_o=1. Timer increments each cycle.
//    Priority: flush_i > ipm_valid_i > timeout.
//     flush_i: -> IDLE, no write, no done, en/sel drop the next cycle.
//     ipm_valid_i: ipm_ready_id_o=1 that cycle; latch ipm_result_i -> WB.
//     timer==TimeoutCycles-1 without valid: ipm_timeout_o pulse, -> IDLE, no write.
//  - WB: ipm_sel_o=1, ipm_en_o=0, stall_id_o=1. rf_we_o=(rd!=0), rf_waddr_o=rd, rf_wdata_o=result,
//    all held stable until rf_ready_i.
//     rd!=0: wait for rf_ready_i; on handshake -> IDLE.
//     rd==0: rf_we_o stays 0; -> IDLE after exactly one cycle, rf_ready_i ignored.
//     On leaving WB: instr_done_o pulses and ipm_retired_o increments.
//    flush_i is ignored in WB: the op has completed.
//  Latency, rf_ready_i tied 1: capture cycle C; BUSY from C+1; valid in cycle V; WB in V+1;
//    write/done in V+1; back in IDLE at V+2.
//  Back-to-back: a new IPM instruction is accepted only in IDLE, so there is at least 1 idle cycle
//    between ops.
//  ipm_valid_i outside BUSY is ignored; ipm_ready_id_o=0 there.
//  Reset mid-operation aborts immediately; no write or pulse is produced.
//  Counter: 32-bit, wraps 0xFFFFFFFF->0. Timer width $clog2(TimeoutCycles+1).
// TESTING
//  1) Op a=0x0000_0003, b=0x0000_0005, rd=7; EX valid 4 cycles after BUSY, result 0x0F, rf_ready=1
//     -> en high 4 cycles; one write x7=0x0F; done pulse; retired=1.
//  2) rd=0, valid after 2 cycles -> rf_we_o never high; done pulse; retired increments.
//  3) flush_i in 2nd BUSY cycle -> en/sel low next cycle; no write, no done; late valid ignored.
//  4) TimeoutCycles=8, no valid -> ipm_timeout_o pulse on 8th BUSY cycle; IDLE next; no write.
//  5) rf_ready_i low 3 cycles in WB -> rf_we/waddr/wdata stable 4 cycles; done on the grant cycle;
//     flush_i during WB has no effect.
//  6) Preload retired=0xFFFFFFFF via forced value, retire one op -> retired=0; async reset
//     asserted in BUSY -> all outputs 0 immediately.

Source files
------------

// File: rtl/ibex_ipm_issue.sv
// ibex_ipm_issue: ID-side initiator for the EX-stage IPM unit.
// Captures a decoded IPM instruction, drives the IPM unit while stalling ID,
// then writes the result back through a valid/ready register-file port.
// Also handles controller flushes, a hang timeout and a retired-op counter.

package ibex_ipm_pkg;

  typedef enum logic [1:0] {
    IPM_OP_MUL = 2'd0,
    IPM_OP_MAC = 2'd1,
    IPM_OP_SQR = 2'd2,
    IPM_OP_INV = 2'd3
  } ipm_op_e;

endpackage

module ibex_ipm_issue
  import ibex_ipm_pkg::*;
#(
  parameter int unsigned TimeoutCycles = 64
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        instr_valid_i,
  input  logic        ipm_instr_i,
  input  ipm_op_e     ipm_operator_i,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  input  logic [4:0]  rd_addr_i,
  input  logic        flush_i,
  output logic        stall_id_o,
  output logic        instr_done_o,
  output logic        ipm_timeout_o,
  output ipm_op_e     ipm_operator_o,
  output logic [31:0] ipm_operand_a_o,
  output logic [31:0] ipm_operand_b_o,
  output logic        ipm_en_o,
  output logic        ipm_sel_o,
  output logic        ipm_ready_id_o,
  input  logic [31:0] ipm_result_i,
  input  logic        ipm_valid_i,
  output logic        rf_we_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o,
  input  logic        rf_ready_i,
  output logic [31:0] ipm_retired_o
);

  localparam int unsigned TimerW = $clog2(TimeoutCycles + 1);
  // Timer value seen in the last BUSY cycle that may still receive a result.
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TimeoutCycles - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_WB   = 2'd2;

  logic [1:0]        state_r;
  logic [1:0]        state_nxt_s;
  ipm_op_e           op_r;
  logic [31:0]       opa_r;
  logic [31:0]       opb_r;
  logic [4:0]        rd_r;
  logic [31:0]       result_r;
  logic [TimerW-1:0] timer_r;
  logic [31:0]       retired_r;

  logic capture_s;
  logic accept_s;
  logic timeout_s;
  logic done_s;
  logic rd_zero_s;

  assign rd_zero_s = (rd_r == 5'd0);

  // Next-state logic and the single-cycle event strobes of the sequencer.
  always_comb begin
    state_nxt_s = state_r;
    capture_s   = 1'b0;
    accept_s    = 1'b0;
    timeout_s   = 1'b0;
    done_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (instr_valid_i && ipm_instr_i && !flush_i) begin
          capture_s   = 1'b1;
          state_nxt_s = ST_BUSY;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        // A flush wins over a simultaneous result, which wins over the timeout.
        if (flush_i) begin
          state_nxt_s = ST_IDLE;
        end else if (ipm_valid_i) begin
          accept_s    = 1'b1;
          state_nxt_s = ST_WB;
        end else if (timer_r == TimerLast) begin
          timeout_s   = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_BUSY;
        end
      end
      ST_WB: begin
        // The op has completed, so a flush no longer matters here; a write to
        // x0 is dropped and retires after exactly one cycle.
        if (rd_zero_s || rf_ready_i) begin
          done_s      = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WB;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Operand/operator/destination capture, held stable for the whole op.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_r  <= IPM_OP_MUL;
      opa_r <= 32'd0;
      opb_r <= 32'd0;
      rd_r  <= 5'd0;
    end else if (capture_s) begin
      op_r  <= ipm_operator_i;
      opa_r <= rs1_data_i;
      opb_r <= rs2_data_i;
      rd_r  <= rd_addr_i;
    end else begin
      op_r  <= op_r;
      opa_r <= opa_r;
      opb_r <= opb_r;
      rd_r  <= rd_r;
    end
  end

  // Result latch, loaded on the EX handshake and held through write-back.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      result_r <= 32'd0;
    end else if (accept_s) begin
      result_r <= ipm_result_i;
    end else begin
      result_r <= result_r;
    end
  end

  // Hang timer: cleared on capture, counts BUSY cycles.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      timer_r <= '0;
    end else if (capture_s) begin
      timer_r <= '0;
    end else if (state_r == ST_BUSY) begin
      timer_r <= timer_r + {{(TimerW-1){1'b0}}, 1'b1};
    end else begin
      timer_r <= timer_r;
    end
  end

  // Retired-op counter, free-running wrap at 2^32.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      retired_r <= 32'd0;
    end else if (done_s) begin
      retired_r <= retired_r + 32'd1;
    end else begin
      retired_r <= retired_r;
    end
  end

  // Output decode: everything is a function of the state registers, except the
  // capture-cycle stall and the BUSY/WB handshake strobes.
  always_comb begin
    stall_id_o      = 1'b0;
    instr_done_o    = 1'b0;
    ipm_timeout_o   = 1'b0;
    ipm_operator_o  = IPM_OP_MUL;
    ipm_operand_a_o = 32'd0;
    ipm_operand_b_o = 32'd0;
    ipm_en_o        = 1'b0;
    ipm_sel_o       = 1'b0;
    ipm_ready_id_o  = 1'b0;
    rf_we_o         = 1'b0;
    rf_waddr_o      = 5'd0;
    rf_wdata_o      = 32'd0;
    case (state_r)
      ST_IDLE: begin
        stall_id_o = capture_s;
      end
      ST_BUSY: begin
        stall_id_o      = 1'b1;
        ipm_en_o        = 1'b1;
        ipm_sel_o       = 1'b1;
        ipm_operator_o  = op_r;
        ipm_operand_a_o = opa_r;
        ipm_operand_b_o = opb_r;
        ipm_ready_id_o  = accept_s;
        ipm_timeout_o   = timeout_s;
      end
      ST_WB: begin
        stall_id_o      = 1'b1;
        ipm_sel_o       = 1'b1;
        ipm_operator_o  = op_r;
        ipm_operand_a_o = opa_r;
        ipm_operand_b_o = opb_r;
        rf_we_o         = !rd_zero_s;
        rf_waddr_o      = rd_r;
        rf_wdata_o      = result_r;
        instr_done_o    = done_s;
      end
      default: begin
        stall_id_o = 1'b0;
      end
    endcase
  end

  assign ipm_retired_o = retired_r;

endmodule
